// File: rtl/mcu_mem_responder.sv
// MCU32X data-bus target: word SRAM, a four-register GPIO page and an error
// response for unmapped, misaligned or read+write requests. A fixed number of
// wait states is inserted before the one-cycle mem_ready pulse.
//
// state  | meaning
// IDLE   | sampling mem_read/mem_write; request fields latched on acceptance
// WAIT   | counting down the configured wait states
// RESP   | completing the access; write commits and response registers load
module mcu_mem_responder #(
    parameter int          DEPTH         = 1024,
    parameter int          WAIT_STATES   = 1,
    parameter logic [31:0] GPIO_BASE     = 32'h4000_0000,
    parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_strb,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        bus_err,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_dir,
    input  logic [31:0] gpio_in,
    output logic [31:0] access_count
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SRAM_BYTES = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  WAIT_LOAD  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_strb;
    logic        lat_read;
    logic        lat_write;

    logic [31:0] sram [DEPTH];
    logic [31:0] gpio_sync1;
    logic [31:0] gpio_sync2;

    logic          misaligned;
    logic          rw_conflict;
    logic          sram_hit;
    logic          gpio_hit;
    logic          any_err;
    logic          do_write;
    logic [AW-1:0] sram_idx;
    logic [31:0]   lane_mask;
    logic [31:0]   rd_data;

    // Decode the latched request and build the read word for the RESP edge
    always_comb begin
        misaligned  = (lat_addr[1:0] != 2'b00);
        rw_conflict = lat_read & lat_write;
        sram_hit    = ({1'b0, lat_addr} < SRAM_BYTES);
        gpio_hit    = (lat_addr[31:4] == GPIO_BASE[31:4]);
        sram_idx    = lat_addr[AW+1:2];
        any_err     = misaligned | rw_conflict | ~(sram_hit | gpio_hit);
        do_write    = lat_write & ~lat_read & ~misaligned;
        lane_mask   = {{8{lat_strb[3]}}, {8{lat_strb[2]}}, {8{lat_strb[1]}}, {8{lat_strb[0]}}};
        rd_data     = 32'h0;
        if (lat_read && !lat_write && !misaligned) begin
            if (sram_hit) begin
                rd_data = sram[sram_idx];
            end else if (gpio_hit) begin
                case (lat_addr[3:2])
                    2'd0:    rd_data = gpio_out;
                    2'd1:    rd_data = gpio_dir;
                    2'd2:    rd_data = gpio_sync2;
                    default: rd_data = access_count;
                endcase
            end else begin
                rd_data = UNMAPPED_DATA;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous GPIO input pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_sync1 <= 32'h0;
            gpio_sync2 <= 32'h0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
        end
    end

    // SRAM byte-lane write; state is cleared asynchronously, so a reset during
    // WAIT never reaches RESP and the write is dropped
    always_ff @(posedge clk) begin
        if (state == S_RESP && do_write && sram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_strb[i]) begin
                    sram[sram_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    // Bus FSM, GPIO registers, transaction counter and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= 4'd0;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            lat_strb     <= 4'h0;
            lat_read     <= 1'b0;
            lat_write    <= 1'b0;
            mem_ready    <= 1'b0;
            bus_err      <= 1'b0;
            mem_rdata    <= 32'h0;
            gpio_out     <= 32'h0;
            gpio_dir     <= 32'h0;
            access_count <= 32'h0;
        end else begin
            mem_ready <= 1'b0;
            bus_err   <= 1'b0;
            mem_rdata <= 32'h0;
            case (state)
                S_IDLE: begin
                    if (mem_read || mem_write) begin
                        lat_addr  <= mem_addr;
                        lat_wdata <= mem_wdata;
                        lat_strb  <= mem_strb;
                        lat_read  <= mem_read;
                        lat_write <= mem_write;
                        wait_cnt  <= WAIT_LOAD;
                        state     <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    mem_ready    <= 1'b1;
                    bus_err      <= any_err;
                    mem_rdata    <= rd_data;
                    access_count <= access_count + 32'd1;
                    if (do_write && gpio_hit && !sram_hit) begin
                        case (lat_addr[3:2])
                            2'd0:    gpio_out <= (gpio_out & ~lane_mask) | (lat_wdata & lane_mask);
                            2'd1:    gpio_dir <= (gpio_dir & ~lane_mask) | (lat_wdata & lane_mask);
                            default: ;
                        endcase
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_mem_responder.sv
// Scoreboard bench: two responders (1 and 0 wait states), directed vectors.
module tb_mcu_mem_responder;

    localparam logic [31:0] GB = 32'h4000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] gpio_in = 32'h0000_00A5;

    logic [31:0] a_addr = '0, a_wdata = '0, a_rdata, a_gout, a_gdir, a_count;
    logic [3:0]  a_strb = '0;
    logic        a_read = 1'b0, a_write = 1'b0, a_ready, a_err;

    logic [31:0] b_addr = '0, b_wdata = '0, b_rdata, b_gout, b_gdir, b_count;
    logic [3:0]  b_strb = '0;
    logic        b_read = 1'b0, b_write = 1'b0, b_ready, b_err;

    mcu_mem_responder #(.WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_strb(a_strb), .mem_read(a_read), .mem_write(a_write),
        .mem_rdata(a_rdata), .mem_ready(a_ready), .bus_err(a_err),
        .gpio_out(a_gout), .gpio_dir(a_gdir), .gpio_in(gpio_in),
        .access_count(a_count)
    );

    mcu_mem_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_strb(b_strb), .mem_read(b_read), .mem_write(b_write),
        .mem_rdata(b_rdata), .mem_ready(b_ready), .bus_err(b_err),
        .gpio_out(b_gout), .gpio_dir(b_gdir), .gpio_in(gpio_in),
        .access_count(b_count)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor for the 1-wait-state responder
    always @(negedge clk) begin
        exp_t e;
        if (a_ready) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ready_ws1 at cycle %0d: rdata=%h err=%b", cyc, a_rdata, a_err);
            end else begin
                e = q1.pop_front();
                if (a_rdata !== e.rdata || a_err !== e.err || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL %s: got rdata=%h err=%b cycle=%0d expected rdata=%h err=%b cycle=%0d",
                             e.name, a_rdata, a_err, cyc, e.rdata, e.err, e.cyc);
                end
            end
        end
    end

    // Monitor for the 0-wait-state responder
    always @(negedge clk) begin
        exp_t e;
        if (b_ready) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ready_ws0 at cycle %0d: rdata=%h err=%b", cyc, b_rdata, b_err);
            end else begin
                e = q0.pop_front();
                if (b_rdata !== e.rdata || b_err !== e.err || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL %s: got rdata=%h err=%b cycle=%0d expected rdata=%h err=%b cycle=%0d",
                             e.name, b_rdata, b_err, cyc, e.rdata, e.err, e.cyc);
                end
            end
        end
    end

    // One transaction on the 1-wait-state responder; ready expected 3 cycles after issue
    task automatic xact1(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st,
                         input logic [31:0] er, input logic ee, input string nm);
        exp_t e;
        int k;
        @(negedge clk);
        a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd; a_strb = st;
        e.rdata = er; e.err = ee; e.cyc = cyc + 3; e.name = nm;
        q1.push_back(e);
        n_txn++;
        @(posedge clk);
        #1;
        a_read = 1'b0; a_write = 1'b0;
        k = 0;
        while (!a_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_%s: got no mem_ready expected one within 20 cycles", nm);
        end
    endtask

    initial begin
        exp_t e;
        int c;
        #100000;
        $display("FAIL watchdog: got no finish expected completion by 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int c;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, a_ready}, 32'h0);
        check("rst_err",   {31'b0, a_err},   32'h0);
        check("rst_rdata", a_rdata, 32'h0);
        check("rst_gout",  a_gout,  32'h0);
        check("rst_gdir",  a_gdir,  32'h0);
        check("rst_count", a_count, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Held read on the 0-wait-state responder, address moved during each RESP
        c = cyc;
        b_read = 1'b1; b_addr = GB + 32'hC;
        e.rdata = 32'h0;  e.err = 1'b0; e.cyc = c + 2; e.name = "held_txn1_count"; q0.push_back(e);
        e.rdata = 32'hA5; e.err = 1'b0; e.cyc = c + 4; e.name = "held_txn2_gpio_in"; q0.push_back(e);
        e.rdata = 32'h2;  e.err = 1'b0; e.cyc = c + 6; e.name = "held_txn3_count"; q0.push_back(e);
        @(negedge clk); b_addr = GB + 32'h8;
        @(negedge clk);
        @(negedge clk); b_addr = GB + 32'hC;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); b_read = 1'b0;
        repeat (3) @(negedge clk);
        check("held_access_count", b_count, 32'd3);

        // SRAM write/read and byte strobes
        xact1(1'b0, 1'b1, 32'h10, 32'h1234_5678, 4'hF, 32'h0, 1'b0, "wr_10");
        xact1(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h1234_5678, 1'b0, "rd_10");
        xact1(1'b0, 1'b1, 32'h14, 32'h1122_3344, 4'hF, 32'h0, 1'b0, "wr_14_full");
        xact1(1'b0, 1'b1, 32'h14, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, "wr_14_strb");
        xact1(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, "rd_14_merged");
        xact1(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, "wr_10_nostrb");
        xact1(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h1234_5678, 1'b0, "rd_10_unchanged");

        // GPIO page
        xact1(1'b0, 1'b1, GB + 32'h4, 32'hFFFF_0000, 4'hF, 32'h0, 1'b0, "wr_gpio_dir");
        check("gpio_dir", a_gdir, 32'hFFFF_0000);
        xact1(1'b0, 1'b1, GB, 32'h1234_A55A, 4'b0011, 32'h0, 1'b0, "wr_gpio_out");
        check("gpio_out", a_gout, 32'h0000_A55A);
        xact1(1'b1, 1'b0, GB, 32'h0, 4'h0, 32'h0000_A55A, 1'b0, "rd_gpio_out");
        xact1(1'b1, 1'b0, GB + 32'h8, 32'h0, 4'h0, 32'h0000_00A5, 1'b0, "rd_gpio_in");
        xact1(1'b0, 1'b1, GB + 32'h8, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, "wr_gpio_in_ignored");
        xact1(1'b1, 1'b0, GB + 32'h8, 32'h0, 4'h0, 32'h0000_00A5, 1'b0, "rd_gpio_in_again");

        // Error responses
        xact1(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, "rd_unmapped");
        xact1(1'b0, 1'b1, 32'h8000_0000, 32'h1, 4'hF, 32'h0, 1'b1, "wr_unmapped");
        xact1(1'b1, 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, "rd_misaligned");
        xact1(1'b0, 1'b1, 32'h20, 32'h5555_AAAA, 4'hF, 32'h0, 1'b0, "wr_20");
        xact1(1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "rdwr_20");
        xact1(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h5555_AAAA, 1'b0, "rd_20_unchanged");
        xact1(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, "rd_past_sram");

        // Counter read returns the pre-increment value
        xact1(1'b1, 1'b0, GB + 32'hC, 32'h0, 4'h0, 32'(n_txn), 1'b0, "rd_access_count");
        check("access_count", a_count, 32'(n_txn));

        // Reset while a write to 0x30 sits in WAIT
        xact1(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "wr_30");
        @(negedge clk);
        a_write = 1'b1; a_addr = 32'h30; a_wdata = 32'h0BAD_BEEF; a_strb = 4'hF;
        @(posedge clk);
        #1;
        a_write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_txn = 0;
        repeat (3) @(negedge clk);
        check("abort_gout",  a_gout,  32'h0);
        check("abort_gdir",  a_gdir,  32'h0);
        check("abort_count", a_count, 32'h0);
        xact1(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "rd_30_after_abort");
        xact1(1'b1, 1'b0, GB + 32'hC, 32'h0, 4'h0, 32'h1, 1'b0, "rd_count_after_abort");

        repeat (4) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 32'h0);
        check("q0_drained", 32'(q0.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
